// File: rtl/align_traceback.sv
// align_traceback: walks the direction-pointer matrix from the best cell toward the origin
// and emits one alignment op per step on a valid/ready stream.
module align_traceback #(
  parameter int QLEN = 32,
  parameter int SLEN = 32,
  parameter int RW   = $clog2(QLEN + 1),
  parameter int CW   = $clog2(SLEN + 1),
  parameter int LW   = $clog2(QLEN + SLEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [RW-1:0] start_row,
  input  logic [CW-1:0] start_col,
  input  logic          abort,
  output logic          ptr_rd,
  output logic [RW-1:0] ptr_row,
  output logic [CW-1:0] ptr_col,
  input  logic [1:0]    ptr_data,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [1:0]    op,
  output logic [RW-1:0] op_row,
  output logic [CW-1:0] op_col,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [LW-1:0] path_len
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, EMIT, DONE} state_t;
  state_t state, nxt;
  logic [RW-1:0] cur_row;
  logic [CW-1:0] cur_col;
  logic border, bad_start, take;
  assign border    = cur_row == '0 || cur_col == '0;
  assign bad_start = int'(start_row) > QLEN || int'(start_col) > SLEN;
  // abort wins over a same-cycle handshake, so the op is not counted
  assign take      = state == EMIT && op_ready && !abort;
  assign ptr_rd    = state == READ && !border;
  assign ptr_row   = cur_row;
  assign ptr_col   = cur_col;
  assign op_valid  = state == EMIT;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? (bad_start ? DONE : READ) : IDLE;
      READ:    nxt = border ? DONE : WAIT;
      WAIT:    nxt = ptr_data == 2'b00 ? DONE : EMIT;
      EMIT:    nxt = op_ready ? READ : EMIT;
      default: nxt = IDLE;
    endcase
    if (abort && state != IDLE) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_row  <= '0;
      cur_col  <= '0;
      op       <= '0;
      op_row   <= '0;
      op_col   <= '0;
      err      <= 1'b0;
      path_len <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        cur_row  <= start_row;
        cur_col  <= start_col;
        path_len <= '0;
        err      <= bad_start;
      end
      if (state == WAIT && ptr_data != 2'b00) begin
        op     <= ptr_data;
        op_row <= cur_row;
        op_col <= cur_col;
      end
      if (take) begin
        if (op != 2'b11) cur_row <= cur_row - RW'(1);
        if (op != 2'b10) cur_col <= cur_col - CW'(1);
        path_len <= path_len + LW'(1);
      end
    end
  end
endmodule

// File: tb/tb_align_traceback.sv
// tb_align_traceback: table-driven directed checks of align_traceback against a pointer-matrix model.
module tb_align_traceback;
  localparam int QLEN = 32, SLEN = 32, RW = 6, CW = 6, LW = 7;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, op_ready = 1'b1;
  logic [RW-1:0] start_row = '0, op_row, ptr_row;
  logic [CW-1:0] start_col = '0, op_col, ptr_col;
  logic [1:0] ptr_data, op;
  logic ptr_rd, op_valid, busy, done, err;
  logic [LW-1:0] path_len;
  logic [1:0] mem [0:QLEN][0:SLEN];
  int cmp = 0, bad = 0;

  typedef struct {
    int sr, sc, kind, stall, pulse, abrt;
    int exp_nops, exp_reads, exp_len, exp_err, exp_done;
    int ops[4];
  } vec_t;
  vec_t tab[7];

  align_traceback #(.QLEN(QLEN), .SLEN(SLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_row(start_row), .start_col(start_col),
    .abort(abort), .ptr_rd(ptr_rd), .ptr_row(ptr_row), .ptr_col(ptr_col), .ptr_data(ptr_data),
    .op_valid(op_valid), .op_ready(op_ready), .op(op), .op_row(op_row), .op_col(op_col),
    .busy(busy), .done(done), .err(err), .path_len(path_len)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (ptr_rd) ptr_data <= mem[ptr_row][ptr_col];

  task automatic chk(input string name, input int got, input int exp);
    cmp++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int pk(input int o, input int r, input int c);
    return o * 4096 + r * 64 + c;
  endfunction

  function automatic vec_t mk(input int sr, input int sc, input int kind, input int stall,
                              input int pulse, input int abrt, input int nops, input int reads,
                              input int len, input int e, input int dc);
    vec_t v;
    v.sr = sr; v.sc = sc; v.kind = kind; v.stall = stall; v.pulse = pulse; v.abrt = abrt;
    v.exp_nops = nops; v.exp_reads = reads; v.exp_len = len; v.exp_err = e; v.exp_done = dc;
    for (int i = 0; i < 4; i++) v.ops[i] = 0;
    return v;
  endfunction

  // kind 0: all DIAG; 1: all DIAG with STOP at (2,2); 2: UP,LEFT,DIAG path from (2,3)
  task automatic fill(input int kind);
    for (int r = 0; r <= QLEN; r++)
      for (int c = 0; c <= SLEN; c++) mem[r][c] = kind == 2 ? 2'b00 : 2'b01;
    if (kind == 1) mem[2][2] = 2'b00;
    if (kind == 2) begin
      mem[2][3] = 2'b10;
      mem[1][3] = 2'b11;
      mem[1][2] = 2'b01;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " ptr_rd"}, ptr_rd, 0);
    chk({tag, " op_valid"}, op_valid, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " err"}, err, 0);
    chk({tag, " op"}, pk(op, op_row, op_col), 0);
    chk({tag, " ptr_addr"}, ptr_row * 64 + ptr_col, 0);
    chk({tag, " path_len"}, path_len, 0);
  endtask

  task automatic run(input vec_t v);
    int cyc = 0, nops = 0, reads = 0, border_reads = 0, stall = 0, done_cyc = -1, e;
    fill(v.kind);
    @(negedge clk);
    start = 1'b1; start_row = RW'(v.sr); start_col = CW'(v.sc); op_ready = 1'b1;
    while (cyc < 300 && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      if (abort) begin
        abort = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort op_valid", op_valid, 0);
        chk("abort ptr_rd", ptr_rd, 0);
        for (int i = 0; i < 5; i++) begin
          chk("abort no done", done, 0);
          @(negedge clk);
        end
        chk("abort ops", nops, v.exp_nops);
        chk("abort path_len", path_len, v.exp_len);
        return;
      end
      start = v.pulse > 0 && cyc == v.pulse;
      if (start) begin start_row = 5; start_col = 5; end
      if (ptr_rd) begin
        reads++;
        if (ptr_row == 0 || ptr_col == 0) border_reads++;
      end
      if (op_valid) begin
        e = v.kind == 2 ? v.ops[nops < 4 ? nops : 3] : pk(1, v.sr - nops, v.sc - nops);
        if (v.abrt > 0 && cyc >= v.abrt) begin
          abort = 1'b1; op_ready = 1'b1;
        end else if (nops == 0 && stall < v.stall) begin
          op_ready = 1'b0; stall++;
          chk("held op", pk(op, op_row, op_col), e);
        end else begin
          op_ready = 1'b1;
          chk($sformatf("op %0d", nops), pk(op, op_row, op_col), e);
          nops++;
        end
      end
      if (done) begin
        done_cyc = cyc;
        chk("done path_len", path_len, v.exp_len);
        chk("done err", err, v.exp_err);
        chk("done busy", busy, 1);
      end
    end
    chk("done cycle", done_cyc, v.exp_done);
    chk("op count", nops, v.exp_nops);
    chk("read count", reads, v.exp_reads);
    chk("border reads", border_reads, 0);
    @(negedge clk);
    chk("done one cycle", done, 0);
    chk("idle after done", busy, 0);
  endtask

  initial begin
    tab[0] = mk(3, 3, 0, 0, 0, 0, 3, 3, 3, 0, 11);
    tab[1] = mk(4, 4, 1, 0, 0, 0, 2, 3, 2, 0, 9);
    tab[2] = mk(2, 3, 2, 5, 0, 0, 3, 3, 3, 0, 16);
    tab[2].ops[0] = pk(2, 2, 3); tab[2].ops[1] = pk(3, 1, 3); tab[2].ops[2] = pk(1, 1, 2);
    tab[3] = mk(0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    tab[4] = mk(QLEN + 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tab[5] = mk(20, 20, 0, 0, 8, 0, 20, 20, 20, 0, 62);
    tab[6] = mk(20, 20, 0, 0, 0, 10, 3, 0, 3, 0, -1);
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) run(tab[i]);
    // asynchronous reset in the middle of a long walk, caught while an op is pending
    fill(0);
    @(negedge clk);
    start = 1'b1; start_row = 20; start_col = 20; op_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-reset op_valid", op_valid, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midwalk reset");
    @(negedge clk);
    rst_n = 1'b1; op_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post-reset no done", done, 0);
    end
    chk("post-reset idle", busy, 0);
    run(tab[0]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
